trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Machine/supervisor trap sequencer between commit stage and fetch. Takes a committed exception or
//  MRET/SRET, updates trap CSRs (xepc/xcause/xtval/mstatus/priv), requests a pipeline flush,
//  waits for the ack, then issues a one-cycle PC redirect. Owns the current privilege level.
// PARAMETERS
//  XLEN         riscv_pkg::RV_XLEN  datapath width
//  MTVEC_RESET  'h8000_0000         mtvec value after reset
//  MEDELEG_MASK 'hB3FF              writable medeleg bits; bit 11 (ecall-M) never delegable
// PORTS
//  clk_i            in   1     clock
//  rst_ni           in   1     reset, asynchronous, active-low
//  ex_valid_i       in   1     committed instruction raised an exception
//  ex_cause_i       in   XLEN  ex_cause_t code
//  ex_tval_i        in   XLEN  faulting address/instruction
//  ex_pc_i          in   XLEN  PC of excepting / xRET instruction
//  mret_i, sret_i   in   1     committed MRET / SRET
//  csr_we_i         in   1     CSR write strobe
//  csr_addr_i       in   12    CSR address
//  csr_wdata_i      in   XLEN  CSR write data
//  csr_rdata_o      out  XLEN  combinational read of csr_addr_i
//  flush_o          out  1     pipeline flush request
//  flush_ack_i      in   1     pipeline drained
//  redirect_valid_o out  1     one-cycle fetch redirect strobe
//  redirect_pc_o    out  XLEN  redirect target
//  busy_o           out  1     high whenever state != IDLE; commit must stall
//  priv_lvl_o       out  2     priv_lvl_t current privilege
// BEHAVIOUR
//  Reset: priv=PRIV_LVL_M; mtvec=MTVEC_RESET; all other CSRs 0; state IDLE; all outputs 0.
//  FSM IDLE -> FLUSH -> REDIRECT -> IDLE.
//  IDLE, priority ex_valid_i > mret_i > sret_i; accepted event moves to FLUSH next cycle:
//   exception: target=S iff priv!=M and medeleg[cause[4:0]]=1, else M. Same edge:
//    xepc<=ex_pc_i; xcause<=ex_cause_i; xtval<=ex_tval_i; xpie<=xie; xie<=0;
//    M: mpp<=priv; S: spp<=priv[0]; priv<=target; target_pc=xtvec & ~3 (direct mode only).
//   mret (priv==M): priv<=mpp; mie<=mpie; mpie<=1; mpp<=U; target_pc=mepc.
//   sret (priv>=S): priv<={1'b0,spp}; sie<=spie; spie<=1; spp<=0; target_pc=sepc.
//   xRET from insufficient privilege: ignored, stay IDLE (decode raises ILLEGAL_INSTR).
//  FLUSH: flush_o=1 continuously; leave on cycle flush_ack_i=1 (ack same cycle as entry allowed).
//  REDIRECT: redirect_valid_o=1, redirect_pc_o=latched target_pc, exactly one cycle; then IDLE.
//  Min latency event->redirect = 2 cycles. redirect_pc_o=0 when redirect_valid_o=0.
//  busy: ex_valid_i/mret_i/sret_i/csr_we_i outside IDLE are dropped.
//  CSR write same cycle as accepted event: event wins, write dropped.
//  CSRs: mstatus, medeleg, mtvec, mepc, mcause, mtval, sstatus(view), stvec, sepc, scause, stval.
//   mepc/sepc/xtvec writes clear bits[1:0]; medeleg write AND MEDELEG_MASK;
//   mstatus writable: sie,mie,spie,mpie,spp,mpp (mpp=2'b10 coerced to U); rest read 0.
//   sstatus reads/writes sie,spie,spp only. Unknown address: read 0, write ignored.
//  Reset mid-operation: async return to reset values; pending flush/redirect abandoned.
// STRUCTURE
//  riscv_pkg: add trap_state_t (IDLE/FLUSH/REDIRECT) and csr_addr_t enum of CSR addresses;
//   reuse ex_cause_t, priv_lvl_t, status_rv64_t.
//  Sub-module trap_csr_file: CSR registers, masked write, read mux; trap_ctrl holds FSM + priv.
// TESTING
//  ILLEGAL_INSTR in M, pc='h100, mtvec='h8000_0000, ack after 3 cyc -> mepc='h100, mcause=2,
//   mpp=M, mie=0, flush_o 3 cyc, redirect 'h8000_0000 one cycle.
//  U-mode ENV_CALL_UMODE with medeleg[8]=1, stvec='h2001 -> priv=S, scause=8, spp=0,
//   redirect 'h2000; same with medeleg[8]=0 -> trap to M.
//  mepc='h400, mpp=U, mpie=1 then mret -> priv=U, mie=1, mpp=U, redirect 'h400.
//  ex_valid_i+mret_i+csr_we_i same cycle -> exception only, CSR unchanged; events during busy ignored.
//  Write medeleg='hFFFF -> reads 'hB3FF; write mstatus.mpp=2'b10 -> reads 00; mret in U ignored.
//  rst_ni low during FLUSH -> flush_o=0 immediately, priv=M, no redirect after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V types for the trap sequencer: privilege levels, exception causes,
// the RV64 mstatus layout, trap FSM states and the CSR address map.
package riscv_pkg;

   localparam int unsigned RV_XLEN = 64;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   typedef enum logic [RV_XLEN-1:0] {
      INSTR_ADDR_MISALIGNED = 64'd0,
      INSTR_ACCESS_FAULT    = 64'd1,
      ILLEGAL_INSTR         = 64'd2,
      BREAKPOINT            = 64'd3,
      LD_ADDR_MISALIGNED    = 64'd4,
      LD_ACCESS_FAULT       = 64'd5,
      ST_ADDR_MISALIGNED    = 64'd6,
      ST_ACCESS_FAULT       = 64'd7,
      ENV_CALL_UMODE        = 64'd8,
      ENV_CALL_SMODE        = 64'd9,
      ENV_CALL_MMODE        = 64'd11,
      INSTR_PAGE_FAULT      = 64'd12,
      LOAD_PAGE_FAULT       = 64'd13,
      STORE_PAGE_FAULT      = 64'd15
   } ex_cause_t;

   typedef struct packed {
      logic        sd;
      logic [26:0] wpri4;
      logic [1:0]  sxl;
      logic [1:0]  uxl;
      logic [8:0]  wpri3;
      logic        tsr;
      logic        tw;
      logic        tvm;
      logic        mxr;
      logic        sum;
      logic        mprv;
      logic [1:0]  xs;
      logic [1:0]  fs;
      logic [1:0]  mpp;
      logic [1:0]  vs;
      logic        spp;
      logic        mpie;
      logic        ube;
      logic        spie;
      logic        wpri2;
      logic        mie;
      logic        wpri1;
      logic        sie;
      logic        wpri0;
   } status_rv64_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2
   } trap_state_t;

   typedef enum logic [11:0] {
      CSR_SSTATUS = 12'h100,
      CSR_STVEC   = 12'h105,
      CSR_SEPC    = 12'h141,
      CSR_SCAUSE  = 12'h142,
      CSR_STVAL   = 12'h143,
      CSR_MSTATUS = 12'h300,
      CSR_MEDELEG = 12'h302,
      CSR_MTVEC   = 12'h305,
      CSR_MEPC    = 12'h341,
      CSR_MCAUSE  = 12'h342,
      CSR_MTVAL   = 12'h343
   } csr_addr_t;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSR storage: masked software writes, trap/xRET side effects and the read mux.
// Trap and xRET updates always take precedence over a software write in the same cycle.
module trap_csr_file
   import riscv_pkg::*;
#(
   parameter int unsigned          XLEN         = RV_XLEN,
   parameter logic [XLEN-1:0]      MTVEC_RESET  = 'h8000_0000,
   parameter logic [XLEN-1:0]      MEDELEG_MASK = 'hB3FF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [11:0]     addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata,
   input  logic            trap_m,
   input  logic            trap_s,
   input  logic            mret,
   input  logic            sret,
   input  priv_lvl_t       priv,
   input  logic [XLEN-1:0] epc,
   input  logic [XLEN-1:0] cause,
   input  logic [XLEN-1:0] tval,
   output logic [XLEN-1:0] medeleg,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] stvec,
   output logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] sepc,
   output logic [1:0]      mpp,
   output logic            spp
);

   logic            sie, mie, spie, mpie;
   logic [XLEN-1:0] mcause, mtval, scause, stval;
   status_rv64_t    mstatus_view, sstatus_view;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sie     <= 1'b0;
         mie     <= 1'b0;
         spie    <= 1'b0;
         mpie    <= 1'b0;
         spp     <= 1'b0;
         mpp     <= 2'b00;
         medeleg <= '0;
         mtvec   <= {MTVEC_RESET[XLEN-1:2], 2'b00};
         stvec   <= '0;
         mepc    <= '0;
         sepc    <= '0;
         mcause  <= '0;
         scause  <= '0;
         mtval   <= '0;
         stval   <= '0;
      end else if (trap_m) begin
         mepc   <= epc;
         mcause <= cause;
         mtval  <= tval;
         mpie   <= mie;
         mie    <= 1'b0;
         mpp    <= priv;
      end else if (trap_s) begin
         sepc   <= epc;
         scause <= cause;
         stval  <= tval;
         spie   <= sie;
         sie    <= 1'b0;
         spp    <= priv[0];
      end else if (mret) begin
         mie  <= mpie;
         mpie <= 1'b1;
         mpp  <= PRIV_LVL_U;
      end else if (sret) begin
         sie  <= spie;
         spie <= 1'b1;
         spp  <= 1'b0;
      end else if (we) begin
         case (addr)
            CSR_MSTATUS: begin
               sie  <= wdata[1];
               mie  <= wdata[3];
               spie <= wdata[5];
               mpie <= wdata[7];
               spp  <= wdata[8];
               // The reserved encoding 2'b10 is not a legal privilege, so it lands in U.
               mpp  <= (wdata[12:11] == 2'b10) ? 2'b00 : wdata[12:11];
            end
            CSR_SSTATUS: begin
               sie  <= wdata[1];
               spie <= wdata[5];
               spp  <= wdata[8];
            end
            CSR_MEDELEG: medeleg <= wdata & MEDELEG_MASK;
            CSR_MTVEC:   mtvec   <= {wdata[XLEN-1:2], 2'b00};
            CSR_STVEC:   stvec   <= {wdata[XLEN-1:2], 2'b00};
            CSR_MEPC:    mepc    <= {wdata[XLEN-1:2], 2'b00};
            CSR_SEPC:    sepc    <= {wdata[XLEN-1:2], 2'b00};
            CSR_MCAUSE:  mcause  <= wdata;
            CSR_SCAUSE:  scause  <= wdata;
            CSR_MTVAL:   mtval   <= wdata;
            CSR_STVAL:   stval   <= wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      mstatus_view      = '0;
      mstatus_view.sie  = sie;
      mstatus_view.mie  = mie;
      mstatus_view.spie = spie;
      mstatus_view.mpie = mpie;
      mstatus_view.spp  = spp;
      mstatus_view.mpp  = mpp;
      sstatus_view      = '0;
      sstatus_view.sie  = sie;
      sstatus_view.spie = spie;
      sstatus_view.spp  = spp;
      rdata             = '0;
      case (addr)
         CSR_MSTATUS: rdata = mstatus_view;
         CSR_SSTATUS: rdata = sstatus_view;
         CSR_MEDELEG: rdata = medeleg;
         CSR_MTVEC:   rdata = mtvec;
         CSR_STVEC:   rdata = stvec;
         CSR_MEPC:    rdata = mepc;
         CSR_SEPC:    rdata = sepc;
         CSR_MCAUSE:  rdata = mcause;
         CSR_SCAUSE:  rdata = scause;
         CSR_MTVAL:   rdata = mtval;
         CSR_STVAL:   rdata = stval;
         default:     rdata = '0;
      endcase
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts a committed exception or xRET, flushes the pipeline, then
// issues a single-cycle fetch redirect. Owns the current privilege level.
module trap_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN         = RV_XLEN,
   parameter logic [XLEN-1:0] MTVEC_RESET  = 'h8000_0000,
   parameter logic [XLEN-1:0] MEDELEG_MASK = 'hB3FF
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_cause_i,
   input  logic [XLEN-1:0] ex_tval_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic            mret_i,
   input  logic            sret_i,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            flush_o,
   input  logic            flush_ack_i,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            busy_o,
   output priv_lvl_t       priv_lvl_o
);

   trap_state_t     state, state_next;
   priv_lvl_t       priv, priv_next;
   logic [XLEN-1:0] target_pc, target_pc_next, tvec;
   logic            delegate, trap_m, trap_s, do_mret, do_sret, csr_we;
   logic [XLEN-1:0] medeleg, mtvec, stvec, mepc, sepc;
   logic [1:0]      mpp;
   logic            spp;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         priv      <= PRIV_LVL_M;
         target_pc <= '0;
      end else begin
         state     <= state_next;
         priv      <= priv_next;
         target_pc <= target_pc_next;
      end
   end

   // Event arbitration only happens in IDLE; anything arriving while busy is dropped.
   always_comb begin
      state_next       = state;
      priv_next        = priv;
      target_pc_next   = target_pc;
      tvec             = mtvec;
      delegate         = 1'b0;
      trap_m           = 1'b0;
      trap_s           = 1'b0;
      do_mret          = 1'b0;
      do_sret          = 1'b0;
      csr_we           = 1'b0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      busy_o           = (state != IDLE);
      case (state)
         IDLE: begin
            if (ex_valid_i) begin
               delegate       = (priv != PRIV_LVL_M) && medeleg[ex_cause_i[4:0]];
               trap_s         = delegate;
               trap_m         = !delegate;
               tvec           = delegate ? stvec : mtvec;
               priv_next      = delegate ? PRIV_LVL_S : PRIV_LVL_M;
               target_pc_next = {tvec[XLEN-1:2], 2'b00};
            end else if (mret_i) begin
               if (priv == PRIV_LVL_M) begin
                  do_mret        = 1'b1;
                  priv_next      = priv_lvl_t'(mpp);
                  target_pc_next = mepc;
               end
            end else if (sret_i) begin
               if (priv != PRIV_LVL_U) begin
                  do_sret        = 1'b1;
                  priv_next      = priv_lvl_t'({1'b0, spp});
                  target_pc_next = sepc;
               end
            end
            if (trap_m || trap_s || do_mret || do_sret) begin
               state_next = FLUSH;
            end else begin
               csr_we = csr_we_i;
            end
         end
         FLUSH: begin
            flush_o = 1'b1;
            if (flush_ack_i) begin
               state_next = REDIRECT;
            end
         end
         REDIRECT: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = target_pc;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign priv_lvl_o = priv;

   trap_csr_file #(
      .XLEN        (XLEN),
      .MTVEC_RESET (MTVEC_RESET),
      .MEDELEG_MASK(MEDELEG_MASK)
   ) u_csr (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .we     (csr_we),
      .addr   (csr_addr_i),
      .wdata  (csr_wdata_i),
      .rdata  (csr_rdata_o),
      .trap_m (trap_m),
      .trap_s (trap_s),
      .mret   (do_mret),
      .sret   (do_sret),
      .priv   (priv),
      .epc    (ex_pc_i),
      .cause  (ex_cause_i),
      .tval   (ex_tval_i),
      .medeleg(medeleg),
      .mtvec  (mtvec),
      .stvec  (stvec),
      .mepc   (mepc),
      .sepc   (sepc),
      .mpp    (mpp),
      .spp    (spp)
   );

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed trap/xRET scenarios followed by random
// traffic, all compared against a CSR/privilege model kept in an associative array.
module tb_trap_ctrl;
   import riscv_pkg::*;

   localparam logic [63:0] MSTATUS_BITS = 64'h19AA;
   localparam logic [63:0] SSTATUS_BITS = 64'h0122;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, mret, sret, csr_we, flush_ack;
   logic [63:0] ex_cause, ex_tval, ex_pc, csr_wdata, csr_rdata, redirect_pc;
   logic [11:0] csr_addr;
   logic        flush, redirect_valid, busy;
   priv_lvl_t   priv_lvl;

   int          check_count = 0;
   int          error_count = 0;

   logic [63:0] m_csr [int];
   logic [1:0]  m_priv;

   logic [11:0] csr_list [12] = '{12'h100, 12'h105, 12'h141, 12'h142, 12'h143, 12'h300,
                                  12'h302, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7C0};
   logic [63:0] cause_list [14] = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6,
                                    64'd7, 64'd8, 64'd9, 64'd11, 64'd12, 64'd13, 64'd15};

   trap_ctrl dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .ex_valid_i      (ex_valid),
      .ex_cause_i      (ex_cause),
      .ex_tval_i       (ex_tval),
      .ex_pc_i         (ex_pc),
      .mret_i          (mret),
      .sret_i          (sret),
      .csr_we_i        (csr_we),
      .csr_addr_i      (csr_addr),
      .csr_wdata_i     (csr_wdata),
      .csr_rdata_o     (csr_rdata),
      .flush_o         (flush),
      .flush_ack_i     (flush_ack),
      .redirect_valid_o(redirect_valid),
      .redirect_pc_o   (redirect_pc),
      .busy_o          (busy),
      .priv_lvl_o      (priv_lvl)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
      end
   endtask

   function automatic void model_reset();
      m_csr.delete();
      m_csr[12'h300] = '0;
      m_csr[12'h302] = '0;
      m_csr[12'h305] = 64'h8000_0000;
      m_csr[12'h341] = '0;
      m_csr[12'h342] = '0;
      m_csr[12'h343] = '0;
      m_csr[12'h105] = '0;
      m_csr[12'h141] = '0;
      m_csr[12'h142] = '0;
      m_csr[12'h143] = '0;
      m_priv = 2'b11;
   endfunction

   function automatic logic [63:0] model_read(input logic [11:0] a);
      if (a == 12'h100) return m_csr[12'h300] & SSTATUS_BITS;
      if (m_csr.exists(int'(a))) return m_csr[int'(a)];
      return '0;
   endfunction

   function automatic void model_write(input logic [11:0] a, input logic [63:0] d);
      logic [63:0] v;
      case (a)
         12'h300: begin
            v = d & MSTATUS_BITS;
            if (v[12:11] == 2'b10) v[12:11] = 2'b00;
            m_csr[12'h300] = v;
         end
         12'h100: m_csr[12'h300] = (m_csr[12'h300] & ~SSTATUS_BITS) | (d & SSTATUS_BITS);
         12'h302: m_csr[12'h302] = d & 64'hB3FF;
         12'h305, 12'h105, 12'h341, 12'h141: m_csr[int'(a)] = d & ~64'h3;
         12'h342, 12'h343, 12'h142, 12'h143: m_csr[int'(a)] = d;
         default: ;
      endcase
   endfunction

   task automatic read_csr(input logic [11:0] a, output logic [63:0] d);
      csr_addr = a;
      #1;
      d = csr_rdata;
   endtask

   // Only called while idle with no strobes asserted, so extra clock edges are harmless.
   task automatic check_all(input string tag);
      logic [63:0] d;
      checkOutput({tag, "_priv"}, 64'(priv_lvl), 64'(m_priv));
      foreach (csr_list[i]) begin
         read_csr(csr_list[i], d);
         checkOutput($sformatf("%s_csr%0h", tag, csr_list[i]), d, model_read(csr_list[i]));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
      csr_we    = 1'b1;
      csr_addr  = a;
      csr_wdata = d;
      @(posedge clk);
      #1;
      csr_we = 1'b0;
      model_write(a, d);
   endtask

   task automatic applyStimulus(input string tag, input bit ev_ex, input bit ev_mret,
                                input bit ev_sret, input logic [63:0] cause,
                                input logic [63:0] pc, input logic [63:0] tval,
                                input int flush_cycles, input bit with_we,
                                input logic [11:0] waddr, input logic [63:0] wdata);
      bit          accepted = 1'b0;
      logic [63:0] target = '0;
      logic [63:0] ms = m_csr[12'h300];
      logic [63:0] md = m_csr[12'h302];
      logic [1:0]  new_priv = m_priv;
      if (ev_ex) begin
         accepted = 1'b1;
         if (m_priv != 2'b11 && md[cause[4:0]]) begin
            m_csr[12'h141] = pc;
            m_csr[12'h142] = cause;
            m_csr[12'h143] = tval;
            ms[5]    = ms[1];
            ms[1]    = 1'b0;
            ms[8]    = m_priv[0];
            new_priv = 2'b01;
            target   = m_csr[12'h105] & ~64'h3;
         end else begin
            m_csr[12'h341] = pc;
            m_csr[12'h342] = cause;
            m_csr[12'h343] = tval;
            ms[7]     = ms[3];
            ms[3]     = 1'b0;
            ms[12:11] = m_priv;
            new_priv  = 2'b11;
            target    = m_csr[12'h305] & ~64'h3;
         end
      end else if (ev_mret) begin
         if (m_priv == 2'b11) begin
            accepted  = 1'b1;
            new_priv  = ms[12:11];
            ms[3]     = ms[7];
            ms[7]     = 1'b1;
            ms[12:11] = 2'b00;
            target    = m_csr[12'h341];
         end
      end else if (ev_sret) begin
         if (m_priv != 2'b00) begin
            accepted = 1'b1;
            new_priv = {1'b0, ms[8]};
            ms[1]    = ms[5];
            ms[5]    = 1'b1;
            ms[8]    = 1'b0;
            target   = m_csr[12'h141];
         end
      end
      m_csr[12'h300] = ms;
      m_priv = new_priv;
      if (!accepted && with_we) model_write(waddr, wdata);

      ex_valid  = ev_ex;
      mret      = ev_mret;
      sret      = ev_sret;
      ex_cause  = cause;
      ex_pc     = pc;
      ex_tval   = tval;
      csr_we    = with_we;
      csr_addr  = waddr;
      csr_wdata = wdata;
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      mret     = 1'b0;
      sret     = 1'b0;
      csr_we   = 1'b0;

      if (accepted) begin
         for (int i = 1; i <= flush_cycles; i++) begin
            checkOutput({tag, "_flush"}, 64'(flush), 64'd1);
            checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
            checkOutput({tag, "_early_redir"}, 64'(redirect_valid), 64'd0);
            flush_ack = (i == flush_cycles);
            ex_valid  = 1'($urandom_range(0, 1));
            mret      = 1'($urandom_range(0, 1));
            sret      = 1'($urandom_range(0, 1));
            csr_we    = 1'($urandom_range(0, 1));
            csr_addr  = csr_list[$urandom_range(0, 11)];
            csr_wdata = {$urandom, $urandom};
            ex_cause  = cause_list[$urandom_range(0, 13)];
            @(posedge clk);
            #1;
            ex_valid = 1'b0;
            mret     = 1'b0;
            sret     = 1'b0;
            csr_we   = 1'b0;
         end
         flush_ack = 1'b0;
         checkOutput({tag, "_redir_valid"}, 64'(redirect_valid), 64'd1);
         checkOutput({tag, "_redir_pc"}, redirect_pc, target);
         checkOutput({tag, "_flush_off"}, 64'(flush), 64'd0);
         @(posedge clk);
         #1;
         checkOutput({tag, "_redir_once"}, 64'(redirect_valid), 64'd0);
         checkOutput({tag, "_redir_pc_zero"}, redirect_pc, 64'd0);
         checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
      end else begin
         checkOutput({tag, "_ign_busy"}, 64'(busy), 64'd0);
         checkOutput({tag, "_ign_flush"}, 64'(flush), 64'd0);
         @(posedge clk);
         #1;
         checkOutput({tag, "_ign_redir"}, 64'(redirect_valid), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] d;
      int          op;
      rst_n     = 1'b0;
      ex_valid  = 1'b0;
      mret      = 1'b0;
      sret      = 1'b0;
      csr_we    = 1'b0;
      flush_ack = 1'b0;
      ex_cause  = '0;
      ex_tval   = '0;
      ex_pc     = '0;
      csr_addr  = '0;
      csr_wdata = '0;
      model_reset();
      #12;
      checkOutput("rst_priv", 64'(priv_lvl), 64'h3);
      checkOutput("rst_flush", 64'(flush), 64'd0);
      checkOutput("rst_redir", 64'(redirect_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      read_csr(12'h305, d);
      checkOutput("rst_mtvec", d, 64'h8000_0000);
      check_all("rst");

      $display("[TB] illegal instruction in M-mode");
      applyStimulus("t1", 1, 0, 0, 64'd2, 64'h100, 64'hDEAD, 3, 0, 12'h0, 64'h0);
      read_csr(12'h341, d);
      checkOutput("t1_mepc", d, 64'h100);
      read_csr(12'h342, d);
      checkOutput("t1_mcause", d, 64'd2);
      read_csr(12'h300, d);
      checkOutput("t1_mpp", 64'(d[12:11]), 64'h3);
      checkOutput("t1_mie", 64'(d[3]), 64'd0);
      check_all("t1");

      $display("[TB] mret to U-mode");
      csr_write(12'h341, 64'h400);
      csr_write(12'h300, 64'h80);
      applyStimulus("t3", 0, 1, 0, 64'd0, 64'h0, 64'h0, 1, 0, 12'h0, 64'h0);
      checkOutput("t3_priv", 64'(priv_lvl), 64'h0);
      read_csr(12'h300, d);
      checkOutput("t3_mie", 64'(d[3]), 64'd1);
      checkOutput("t3_mpp", 64'(d[12:11]), 64'h0);
      check_all("t3");

      $display("[TB] delegated U-mode ecall");
      csr_write(12'h302, 64'h100);
      csr_write(12'h105, 64'h2001);
      applyStimulus("t2", 1, 0, 0, 64'd8, 64'h500, 64'h0, 2, 0, 12'h0, 64'h0);
      checkOutput("t2_priv", 64'(priv_lvl), 64'h1);
      read_csr(12'h142, d);
      checkOutput("t2_scause", d, 64'd8);
      read_csr(12'h100, d);
      checkOutput("t2_spp", 64'(d[8]), 64'd0);
      read_csr(12'h105, d);
      checkOutput("t2_stvec", d, 64'h2000);
      check_all("t2");
      applyStimulus("t2_sret", 0, 0, 1, 64'd0, 64'h0, 64'h0, 1, 0, 12'h0, 64'h0);
      checkOutput("t2_sret_priv", 64'(priv_lvl), 64'h0);
      csr_write(12'h302, 64'h0);
      applyStimulus("t2_m", 1, 0, 0, 64'd8, 64'h504, 64'h0, 1, 0, 12'h0, 64'h0);
      checkOutput("t2_m_priv", 64'(priv_lvl), 64'h3);
      check_all("t2m");

      $display("[TB] simultaneous exception, mret and CSR write");
      applyStimulus("t4", 1, 1, 0, 64'd5, 64'h800, 64'h77, 2, 1, 12'h305, 64'h1234);
      read_csr(12'h305, d);
      checkOutput("t4_mtvec", d, 64'h8000_0000);
      check_all("t4");

      $display("[TB] CSR masking and ignored mret");
      csr_write(12'h302, 64'hFFFF);
      read_csr(12'h302, d);
      checkOutput("t5_medeleg", d, 64'hB3FF);
      csr_write(12'h300, 64'h1000);
      read_csr(12'h300, d);
      checkOutput("t5_mpp", 64'(d[12:11]), 64'h0);
      csr_write(12'h341, 64'h40);
      applyStimulus("t5_mret", 0, 1, 0, 64'd0, 64'h0, 64'h0, 1, 0, 12'h0, 64'h0);
      applyStimulus("t5_ign", 0, 1, 0, 64'd0, 64'h0, 64'h0, 1, 0, 12'h0, 64'h0);
      checkOutput("t5_priv", 64'(priv_lvl), 64'h0);
      check_all("t5");

      $display("[TB] reset during flush");
      ex_valid = 1'b1;
      ex_cause = 64'd2;
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      checkOutput("t6_flush_on", 64'(flush), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_flush_off", 64'(flush), 64'd0);
      checkOutput("t6_priv", 64'(priv_lvl), 64'h3);
      checkOutput("t6_busy", 64'(busy), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("t6_no_redir", 64'(redirect_valid), 64'd0);
         checkOutput("t6_idle", 64'(busy), 64'd0);
      end
      check_all("t6");

      $display("[TB] random traffic");
      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            csr_write(csr_list[$urandom_range(0, 11)], {$urandom, $urandom});
         end else if (op <= 6) begin
            applyStimulus("rnd_ex", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          cause_list[$urandom_range(0, 13)], {$urandom, $urandom},
                          {$urandom, $urandom}, $urandom_range(1, 3),
                          1'($urandom_range(0, 1)), csr_list[$urandom_range(0, 11)],
                          {$urandom, $urandom});
         end else if (op == 7) begin
            applyStimulus("rnd_mret", 0, 1, 0, 64'd0, 64'h0, 64'h0, $urandom_range(1, 3),
                          0, 12'h0, 64'h0);
         end else if (op == 8) begin
            applyStimulus("rnd_sret", 0, 0, 1, 64'd0, 64'h0, 64'h0, $urandom_range(1, 3),
                          0, 12'h0, 64'h0);
         end else begin
            applyStimulus("rnd_both", 0, 1, 1, 64'd0, 64'h0, 64'h0, $urandom_range(1, 3),
                          0, 12'h0, 64'h0);
         end
         check_all("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
